// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide write-back unit.
// Optional divider datapath is enabled by defining MULTDIV_DIV_EN.
package multdiv_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_e;

endpackage

// File: rtl/multdiv_negate.sv
// Two's-complement conditional negate, used for operand magnitudes
// and for applying the result sign.
module multdiv_negate
  import multdiv_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic              negate,
  output logic [DATA_W-1:0] result
);

  assign result = negate ? (~value + DATA_W'(1)) : value;

endmodule

// File: rtl/multdiv_wb_unit.sv
// Iterative signed 32-bit multiply/divide feeding the register-file write port.
// Define MULTDIV_DIV_EN for the restoring divider; otherwise DIV reports an exception.
module multdiv_wb_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic [REG_AW-1:0] ctrl_destReg,
  output logic              ctrl_busy,
  output logic              ctrl_writeEnable,
  output logic [REG_AW-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              data_exception
);

  import multdiv_pkg::*;

  state_e              state;
  state_e              stateNext;
  op_e                 op;
  logic                sign;
  logic                primed;
  logic                dz;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   magA;
  logic [DATA_W-1:0]   magB;
  logic [DATA_W-1:0]   resSigned;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] accNext;
  logic [DATA_W:0]     sum;
  logic [REG_AW-1:0]   destQ;
  logic                multStart;
  logic                divStart;
  logic                divZero;
  logic                lastIter;
  logic                ovf;

  assign multStart = ctrl_MULT & ~ctrl_DIV;
  assign divStart  = ctrl_DIV & ~ctrl_MULT;
  assign lastIter  = primed && (cnt == CNT_W'(ITER_CNT - 1));

`ifdef MULTDIV_DIV_EN
  assign divZero = (data_operandB == '0);
`else
  assign divZero = 1'b1;
`endif

  multdiv_negate uNegA (
    .value  (data_operandA),
    .negate (data_operandA[DATA_W-1]),
    .result (magA)
  );

  multdiv_negate uNegB (
    .value  (data_operandB),
    .negate (data_operandB[DATA_W-1]),
    .result (magB)
  );

  multdiv_negate uNegRes (
    .value  (accNext[DATA_W-1:0]),
    .negate (sign),
    .result (resSigned)
  );

`ifdef MULTDIV_DIV_EN
  logic [2*DATA_W-1:0] shifted;
  logic [DATA_W:0]     diff;
`endif

  // acc holds {hi, lo}: product/multiplier for MULT, remainder/quotient for DIV
  always_comb begin
    accNext = acc;
    sum     = '0;
`ifdef MULTDIV_DIV_EN
    shifted = acc << 1;
    diff    = {1'b0, shifted[2*DATA_W-1:DATA_W]} - {1'b0, operand};
`endif
    unique case (op)
      OP_MULT: begin
        sum = {1'b0, acc[2*DATA_W-1:DATA_W]}
            + (acc[0] ? {1'b0, operand} : '0);
        accNext = {sum, acc[DATA_W-1:1]};
      end
      OP_DIV: begin
`ifdef MULTDIV_DIV_EN
        accNext = diff[DATA_W] ? shifted
                : {diff[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
`else
        accNext = acc;
`endif
      end
      default: accNext = acc;
    endcase
  end

  // only a negative result may reach 2^31 in magnitude
  always_comb begin
    ovf = 1'b0;
    unique case (op)
      OP_MULT:
        ovf = sign
            ? ((accNext[2*DATA_W-1:DATA_W] != '0) ||
               (accNext[DATA_W-1] && (accNext[DATA_W-2:0] != '0)))
            : (accNext[2*DATA_W-1:DATA_W-1] != '0);
      OP_DIV:  ovf = ~sign & accNext[DATA_W-1];
      default: ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state <= IDLE;
    else               state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (multStart || divStart) stateNext = RUN;
      RUN:     if (dz || lastIter) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ctrl_busy        = (state != IDLE);
    ctrl_writeEnable = (state == DONE);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      op             <= OP_MULT;
      sign           <= 1'b0;
      primed         <= 1'b0;
      dz             <= 1'b0;
      cnt            <= '0;
      operand        <= '0;
      acc            <= '0;
      destQ          <= '0;
      ctrl_writeReg  <= '0;
      data_writeReg  <= '0;
      data_exception <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (multStart || divStart) begin
          op      <= multStart ? OP_MULT : OP_DIV;
          sign    <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
          dz      <= divStart && divZero;
          primed  <= 1'b0;
          cnt     <= '0;
          destQ   <= ctrl_destReg;
          operand <= multStart ? magA : magB;
          acc     <= {{DATA_W{1'b0}}, (multStart ? magB : magA)};
        end
        RUN: if (dz) begin
          ctrl_writeReg  <= destQ;
          data_writeReg  <= '0;
          data_exception <= 1'b1;
        end else if (!primed) begin
          primed <= 1'b1;
        end else begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
          if (lastIter) begin
            ctrl_writeReg  <= destQ;
            data_writeReg  <= ovf ? '0 : resSigned;
            data_exception <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_wb_unit.sv
// Directed self-checking bench for multdiv_wb_unit.
// DIV expectations follow MULTDIV_DIV_EN as seen by this compile.
module tb_multdiv_wb_unit;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_destReg;
  logic        ctrl_busy;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        data_exception;

  int total = 0;
  int bad   = 0;

  multdiv_wb_unit #(
    .DATA_W (32),
    .REG_AW (5)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_MULT        (ctrl_MULT),
    .ctrl_DIV         (ctrl_DIV),
    .data_operandA    (data_operandA),
    .data_operandB    (data_operandB),
    .ctrl_destReg     (ctrl_destReg),
    .ctrl_busy        (ctrl_busy),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .data_exception   (data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic runOp(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input int lat,
                       input logic [31:0] expData, input logic expExc,
                       input int injAt);
    int got;
    int idle;
    got  = 0;
    idle = 0;
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    ctrl_destReg  = dest;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
    ctrl_destReg  = 5'd30;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      if (k == injAt) begin
        ctrl_MULT     = d;
        ctrl_DIV      = m;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        ctrl_destReg  = 5'd1;
      end
      if (!ctrl_busy) idle++;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (ctrl_writeEnable) got = k;
    end
    chk({tag, ".lat"}, got, lat);
    chk({tag, ".busyRun"}, idle, 0);
    chk({tag, ".busyDone"}, {31'd0, ctrl_busy}, 1);
    chk({tag, ".reg"}, {27'd0, ctrl_writeReg}, {27'd0, dest});
    chk({tag, ".data"}, data_writeReg, expData);
    chk({tag, ".exc"}, {31'd0, data_exception}, {31'd0, expExc});
    @(posedge clock);
    #1;
    chk({tag, ".weAfter"}, {31'd0, ctrl_writeEnable}, 0);
    chk({tag, ".busyAfter"}, {31'd0, ctrl_busy}, 0);
  endtask

  initial begin
    int seen;
    ctrl_reset_n  = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_destReg  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.busy", {31'd0, ctrl_busy}, 0);
    chk("rst.we", {31'd0, ctrl_writeEnable}, 0);
    chk("rst.reg", {27'd0, ctrl_writeReg}, 0);
    chk("rst.data", data_writeReg, 0);
    chk("rst.exc", {31'd0, data_exception}, 0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;

    runOp("mul7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA, 5'd5, 33,
          32'hFFFF_FFD6, 0, 0);
    runOp("mulOvf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd3, 33,
          32'h0, 1, 0);
    runOp("mulMin", 1, 0, 32'h8000_0000, 32'd1, 5'd4, 33,
          32'h8000_0000, 0, 0);
    runOp("mulNegNeg", 1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd0, 33,
          32'd15, 0, 0);
`ifdef MULTDIV_DIV_EN
    runOp("div-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd9, 33,
          32'hFFFF_FFFD, 0, 0);
    runOp("divOvf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 33,
          32'h0, 1, 0);
    runOp("div6/3", 0, 1, 32'd6, 32'd3, 5'd11, 33, 32'd2, 0, 0);
    runOp("divInj", 0, 1, 32'd100, 32'd7, 5'd12, 33, 32'd14, 0, 10);
`else
    runOp("div-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd9, 1, 32'h0, 1, 0);
    runOp("div6/3", 0, 1, 32'd6, 32'd3, 5'd11, 1, 32'h0, 1, 0);
    runOp("mulInj", 1, 0, 32'd1000, 32'hFFFF_FFFD, 5'd12, 33,
          32'hFFFF_F448, 0, 10);
`endif
    runOp("div5/0", 0, 1, 32'd5, 32'd0, 5'd13, 1, 32'h0, 1, 0);

    @(negedge clock);
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      if (ctrl_busy || ctrl_writeEnable) seen++;
    end
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    chk("both.idle", seen, 0);

    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_destReg  = 5'd20;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (11) @(posedge clock);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, ctrl_busy}, 0);
    chk("abort.we", {31'd0, ctrl_writeEnable}, 0);
    chk("abort.reg", {27'd0, ctrl_writeReg}, 0);
    chk("abort.data", data_writeReg, 0);
    chk("abort.exc", {31'd0, data_exception}, 0);
    @(negedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      #1;
      if (ctrl_writeEnable || ctrl_busy) seen++;
    end
    chk("abort.quiet", seen, 0);

    runOp("mul3x4", 1, 0, 32'd3, 32'd4, 5'd7, 33, 32'd12, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
